// File: rtl/if_id_fetch_stage_if.sv
// if_id_fetch_stage_if
//   Bundle of the signals exchanged between the fetch stage and its
//   surroundings: the hazard unit, EX-stage branch resolution, the
//   instruction memory and the decode stage.
//
// Handshake semantics (the only flow control on this bundle):
//   - if_id_valid qualifies if_id_pc/if_id_inst. 1 means a real fetched
//     instruction. 0 means a bubble whose if_id_inst is the NOP word.
//   - stall acts as an inverted ready from the downstream side. While it
//     is 1 at a rising edge (and branch_taken is 0), the IF/ID contents
//     and the PC do not move. A held IF/ID word is presented again, not
//     consumed twice.
//   - branch_taken is a single-cycle command sampled at the rising edge.
//     It needs no acknowledgement and always wins over stall.
//   - imem_addr -> imem_rdata is a same-cycle combinational read.
//
// Modports:
//   master : fetch-stage side. Drives imem_addr, IF/ID, counters, mode.
//   slave  : environment side. Drives stall, branch_*, imem_rdata.
//
// mode is a debug view of the per-cycle mode selected at the next edge:
//   0 = advance, 1 = stall, 2 = flush.

interface if_id_fetch_stage_if #(
  parameter int PC_W = 64
);
  logic            stall;
  logic            branch_taken;
  logic [PC_W-1:0] branch_target;
  logic [PC_W-1:0] imem_addr;
  logic [31:0]     imem_rdata;
  logic [PC_W-1:0] if_id_pc;
  logic [31:0]     if_id_inst;
  logic            if_id_valid;
  logic [31:0]     stall_count;
  logic [31:0]     flush_count;
  logic [1:0]      mode;

  modport master (
    input  stall,
    input  branch_taken,
    input  branch_target,
    input  imem_rdata,
    output imem_addr,
    output if_id_pc,
    output if_id_inst,
    output if_id_valid,
    output stall_count,
    output flush_count,
    output mode
  );

  modport slave (
    output stall,
    output branch_taken,
    output branch_target,
    output imem_rdata,
    input  imem_addr,
    input  if_id_pc,
    input  if_id_inst,
    input  if_id_valid,
    input  stall_count,
    input  flush_count,
    input  mode
  );
endinterface

// File: rtl/if_id_fetch_stage.sv
// if_id_fetch_stage
//   Instruction-fetch stage plus IF/ID pipeline register of the five-stage
//   RISC-V core. Owns the PC, presents it to instruction memory, and
//   latches the fetched word and its PC into IF/ID.
//
// Ports:
//   clk   : single clock, all state moves on its rising edge.
//   rst_n : asynchronous active-low reset.
//   bus   : if_id_fetch_stage_if.master
//             in : stall, branch_taken, branch_target, imem_rdata
//             out: imem_addr, if_id_pc, if_id_inst, if_id_valid,
//                  stall_count, flush_count, mode (debug)
//
// Per-cycle behaviour is one of three modes, by priority:
//   flush   (branch_taken)        : PC <- target & ~3, IF/ID <- bubble
//   stall   (stall, !branch_taken): PC and IF/ID hold
//   advance (otherwise)           : IF/ID <- {PC, imem_rdata}, PC <- PC + 4
// Both event counters saturate at all-ones.

module if_id_fetch_stage #(
  parameter int              PC_W     = 64,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter logic [31:0]     NOP_INST = 32'h0000_0013
) (
  input  logic                 clk,
  input  logic                 rst_n,
  if_id_fetch_stage_if.master  bus
);

  localparam logic [1:0] MODE_ADVANCE = 2'd0;
  localparam logic [1:0] MODE_STALL   = 2'd1;
  localparam logic [1:0] MODE_FLUSH   = 2'd2;

  localparam logic [PC_W-1:0] PC_STEP  = PC_W'(4);
  localparam logic [PC_W-1:0] LOW_MASK = PC_W'(3);
  localparam logic [31:0]     CNT_MAX  = 32'hFFFF_FFFF;

  // Registered state
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] if_id_pc_q;
  logic [31:0]     if_id_inst_q;
  logic            if_id_valid_q;
  logic [31:0]     stall_count_q;
  logic [31:0]     flush_count_q;

  // Next-state values
  logic [1:0]      mode;
  logic [PC_W-1:0] pc_d;
  logic [PC_W-1:0] if_id_pc_d;
  logic [31:0]     if_id_inst_d;
  logic            if_id_valid_d;
  logic [31:0]     stall_count_d;
  logic [31:0]     flush_count_d;

  // Mode selection: flush beats stall, stall beats advance.
  always_comb begin
    mode = MODE_ADVANCE;
    if (bus.branch_taken) begin
      mode = MODE_FLUSH;
    end else if (bus.stall) begin
      mode = MODE_STALL;
    end
  end

  // Next-state logic
  always_comb begin
    pc_d          = pc_q;
    if_id_pc_d    = if_id_pc_q;
    if_id_inst_d  = if_id_inst_q;
    if_id_valid_d = if_id_valid_q;
    stall_count_d = stall_count_q;
    flush_count_d = flush_count_q;

    case (mode)
      MODE_FLUSH: begin
        // Targets are word aligned; the two low bits are discarded.
        pc_d          = bus.branch_target & ~LOW_MASK;
        if_id_pc_d    = '0;
        if_id_inst_d  = NOP_INST;
        if_id_valid_d = 1'b0;
        if (flush_count_q != CNT_MAX) begin
          flush_count_d = flush_count_q + 32'd1;
        end
      end
      MODE_STALL: begin
        if (stall_count_q != CNT_MAX) begin
          stall_count_d = stall_count_q + 32'd1;
        end
      end
      default: begin
        if_id_pc_d    = pc_q;
        if_id_inst_d  = bus.imem_rdata;
        if_id_valid_d = 1'b1;
        // Modulo 2^PC_W: the carry out of the top bit is dropped.
        pc_d          = pc_q + PC_STEP;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      if_id_pc_q    <= '0;
      if_id_inst_q  <= NOP_INST;
      if_id_valid_q <= 1'b0;
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      pc_q          <= pc_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_inst_q  <= if_id_inst_d;
      if_id_valid_q <= if_id_valid_d;
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  // Outputs: imem_addr is the PC register itself, no extra delay.
  always_comb begin
    bus.imem_addr   = pc_q;
    bus.if_id_pc    = if_id_pc_q;
    bus.if_id_inst  = if_id_inst_q;
    bus.if_id_valid = if_id_valid_q;
    bus.stall_count = stall_count_q;
    bus.flush_count = flush_count_q;
    bus.mode        = mode;
  end

endmodule

// File: tb/tb_if_id_fetch_stage.sv
module tb_if_id_fetch_stage;

  localparam int          PC_W = 64;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_failed;

  if_id_fetch_stage_if #(.PC_W(PC_W)) bus ();

  if_id_fetch_stage #(
    .PC_W     (PC_W),
    .RESET_PC ('0),
    .NOP_INST (NOP)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- instruction memory model ----------------
  // PC 0 and 4 hold the two test words; elsewhere {addr[19:0], 12'h013}.
  always_comb begin
    if (bus.imem_addr == 64'd0)
      bus.imem_rdata = 32'h0050_0093;
    else if (bus.imem_addr == 64'd4)
      bus.imem_rdata = 32'h0070_0113;
    else
      bus.imem_rdata = {bus.imem_addr[19:0], 12'h013};
  end

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_failed++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change on the falling edge; checks also happen there.
  task automatic step(input logic st, input logic bt, input logic [63:0] tgt);
    bus.stall         = st;
    bus.branch_taken  = bt;
    bus.branch_target = tgt;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_ifid(input string tag, input logic [63:0] pc, input logic [31:0] inst,
                            input logic vld, input logic [63:0] addr);
    check({tag, ".if_id_pc"},    bus.if_id_pc,    pc);
    check({tag, ".if_id_inst"},  {32'd0, bus.if_id_inst}, {32'd0, inst});
    check({tag, ".if_id_valid"}, {63'd0, bus.if_id_valid}, {63'd0, vld});
    check({tag, ".imem_addr"},   bus.imem_addr,   addr);
  endtask

  initial begin
    n_tests  = 0;
    n_failed = 0;
    rst_n             = 1'b0;
    bus.stall         = 1'b0;
    bus.branch_taken  = 1'b0;
    bus.branch_target = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check_ifid("reset", 64'd0, NOP, 1'b0, 64'd0);
    check("reset.stall_count", {32'd0, bus.stall_count}, 64'd0);
    check("reset.flush_count", {32'd0, bus.flush_count}, 64'd0);

    // Reset then advance
    rst_n = 1'b1;
    step(1'b0, 1'b0, '0);
    check_ifid("adv1", 64'd0, 32'h0050_0093, 1'b1, 64'd4);
    step(1'b0, 1'b0, '0);
    check_ifid("adv2", 64'd4, 32'h0070_0113, 1'b1, 64'd8);
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b0, '0);
    check_ifid("adv4", 64'd12, 32'h0000_C013, 1'b1, 64'd16);

    // Load-use stall, two cycles at PC 16
    step(1'b1, 1'b0, '0);
    check_ifid("stall1", 64'd12, 32'h0000_C013, 1'b1, 64'd16);
    step(1'b1, 1'b0, '0);
    check_ifid("stall2", 64'd12, 32'h0000_C013, 1'b1, 64'd16);
    check("stall.stall_count", {32'd0, bus.stall_count}, 64'd2);
    step(1'b0, 1'b0, '0);
    check_ifid("post_stall", 64'd16, 32'h0001_0013, 1'b1, 64'd20);

    // Branch flush to 0x40
    step(1'b0, 1'b1, 64'h40);
    check_ifid("flush", 64'd0, NOP, 1'b0, 64'h40);
    check("flush.flush_count", {32'd0, bus.flush_count}, 64'd1);
    check("flush.stall_count", {32'd0, bus.stall_count}, 64'd2);
    step(1'b0, 1'b0, '0);
    check_ifid("post_flush", 64'h40, 32'h0004_0013, 1'b1, 64'h44);

    // Stall and flush together, misaligned target
    step(1'b1, 1'b1, 64'h83);
    check_ifid("stall_flush", 64'd0, NOP, 1'b0, 64'h80);
    check("stall_flush.stall_count", {32'd0, bus.stall_count}, 64'd2);
    check("stall_flush.flush_count", {32'd0, bus.flush_count}, 64'd2);
    step(1'b0, 1'b0, '0);
    check_ifid("post_sf", 64'h80, 32'h0008_0013, 1'b1, 64'h84);

    // PC wrap: redirect to 2^64-4, then advance
    step(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
    check_ifid("wrap_tgt", 64'd0, NOP, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC);
    step(1'b0, 1'b0, '0);
    check_ifid("wrap", 64'hFFFF_FFFF_FFFF_FFFC, 32'hFFFF_C013, 1'b1, 64'd0);
    check("wrap.flush_count", {32'd0, bus.flush_count}, 64'd3);

    // Build stall_count up to 5, then async reset between edges
    step(1'b1, 1'b0, '0);
    step(1'b1, 1'b0, '0);
    step(1'b1, 1'b0, '0);
    check("pre_rst.stall_count", {32'd0, bus.stall_count}, 64'd5);
    check_ifid("pre_rst", 64'hFFFF_FFFF_FFFF_FFFC, 32'hFFFF_C013, 1'b1, 64'd0);
    #2 rst_n = 1'b0;
    #1;
    check_ifid("async_rst", 64'd0, NOP, 1'b0, 64'd0);
    check("async_rst.stall_count", {32'd0, bus.stall_count}, 64'd0);
    check("async_rst.flush_count", {32'd0, bus.flush_count}, 64'd0);

    // Release and confirm clean restart
    @(negedge clk);
    bus.stall = 1'b0;
    rst_n = 1'b1;
    step(1'b0, 1'b0, '0);
    check_ifid("restart", 64'd0, 32'h0050_0093, 1'b1, 64'd4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end

endmodule

// File: doc/if_id_fetch_stage.md
# if_id_fetch_stage

Instruction-fetch stage and IF/ID pipeline register for the five-stage RISC-V core. It owns the program counter, drives the instruction-memory address, and latches the fetched word and its PC into the IF/ID register. The IF/ID instruction feeds the hazard detection unit's `inst` input. The unit's `stall` output returns to this block to freeze the PC and IF/ID. EX-stage branch resolution redirects the PC and flushes IF/ID.

## Interface
- `PC_W`, default 64: program-counter width in bits.
- `RESET_PC`, default 0: PC value loaded on reset.
- `NOP_INST`, default 32'h00000013: bubble word (`addi x0,x0,0`) inserted on reset and flush.
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `stall` input 1: load-use stall from the hazard detection unit; holds PC and IF/ID.
- `branch_taken` input 1: EX-stage redirect request.
- `branch_target` input PC_W: redirect address; bits [1:0] are ignored and treated as 0.
- `imem_addr` output PC_W: combinational copy of the current PC.
- `imem_rdata` input 32: instruction word at `imem_addr`, combinational (same-cycle) memory.
- `if_id_pc` output PC_W: PC of the instruction held in IF/ID.
- `if_id_inst` output 32: instruction held in IF/ID; drives the hazard unit's `inst`.
- `if_id_valid` output 1: 1 when IF/ID holds a real fetched instruction; 0 for a bubble.
- `stall_count` output 32: saturating count of cycles with `stall` accepted.
- `flush_count` output 32: saturating count of cycles with `branch_taken` asserted.

## Operation
- The state is: the PC register, the IF/ID register (`pc`, `inst`, `valid`), and the two counters. There is no other FSM; per-cycle behaviour is one of three modes, chosen by priority.
- **Priority 1, flush** (`branch_taken`=1, regardless of `stall`):
  - PC ← {`branch_target`[PC_W-1:2], 2'b00}.
  - `if_id_inst` ← NOP_INST, `if_id_valid` ← 0, `if_id_pc` ← 0.
  - `flush_count` increments; `stall_count` does not.
- **Priority 2, stall** (`stall`=1, `branch_taken`=0):
  - PC and the whole IF/ID register hold their values.
  - `stall_count` increments.
- **Priority 3, advance** (otherwise):
  - `if_id_pc` ← PC, `if_id_inst` ← `imem_rdata`, `if_id_valid` ← 1.
  - PC ← PC + 4, modulo 2^PC_W; wrap from all-ones-minus-3 to 0 is silent.
- The counters saturate at 32'hFFFF_FFFF. At saturation they hold; they never wrap.
- `imem_addr` equals the PC register at all times. It carries no registered delay beyond the PC itself.

## Timing
- Reset values while `rst_n`=0, applied asynchronously at the falling edge of `rst_n`:
  - PC = RESET_PC, so `imem_addr` = RESET_PC.
  - `if_id_pc` = 0, `if_id_inst` = NOP_INST, `if_id_valid` = 0.
  - `stall_count` = 0, `flush_count` = 0.
- Reset release: the first rising edge with `rst_n`=1 performs the normal mode selection. In advance mode, IF/ID captures RESET_PC and `imem_rdata` at that edge.
- Fetch latency: an instruction appears on `if_id_inst` one cycle after its PC appears on `imem_addr`.
- Stall: holding is exact. A stall of N cycles re-presents the same IF/ID contents for N extra cycles. The first edge after `stall` drops advances normally.
- Redirect: the target is on `imem_addr` in the cycle after `branch_taken`. The target instruction reaches IF/ID one cycle later, so a taken branch costs exactly one bubble in IF/ID.
- Simultaneous `stall` and `branch_taken`: the flush wins. The stalled IF/ID instruction is discarded and the PC takes the target.
- Reset mid-operation: asynchronous, and overrides any stall or flush in progress. No partial update survives.
- `stall`, `branch_taken` and `branch_target` are sampled only at the rising edge. Glitches between edges have no effect.

## Test plan
- **Reset then advance.** Release `rst_n` with imem returning 32'h00500093 at PC 0, 32'h00700113 at PC 4.
  - Required: `imem_addr` = 0 during reset.
  - After edge 1: `if_id_inst` = 32'h00500093, `if_id_pc` = 0, `if_id_valid` = 1.
  - After edge 2: `if_id_pc` = 4, `imem_addr` = 8.
- **Load-use stall.** Assert `stall` for 2 cycles with PC = 16.
  - Required: `imem_addr` stays 16 and IF/ID is unchanged for both cycles; `stall_count` = 2.
  - Next edge: `if_id_pc` = 16, `imem_addr` = 20.
- **Branch flush.** `branch_taken`=1 with `branch_target` = 0x40.
  - Required next cycle: `imem_addr` = 0x40, `if_id_inst` = 32'h00000013, `if_id_valid` = 0, `flush_count` = 1.
  - Cycle after: `if_id_pc` = 0x40.
- **Stall plus flush in the same cycle**, with `branch_target` = 0x83.
  - Required: `imem_addr` = 0x80 (low bits cleared), IF/ID holds a bubble, `stall_count` unchanged.
- **PC wrap.** Force PC to 2^64-4 and advance one cycle.
  - Required: `if_id_pc` = 2^64-4 and `imem_addr` = 0.
- **Asynchronous reset mid-stall.** Drop `rst_n` between clock edges while `stall`=1 and `stall_count` = 5.
  - Required, immediately: `imem_addr` = RESET_PC, `if_id_valid` = 0, `stall_count` = 0.
